fpir_add_arbiter: RTL and testbench



---
 rtl/fpir_add_arbiter.sv | 174 +++++++++++++++++
 tb/tb_fpir_add_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fpir_add_arbiter.sv
// Round-robin arbiter sharing one fixed-latency FPIR adder among NUM_REQ requesters.
// Results return through a tag pipeline into a credit-protected response FIFO.

module fpir_add_arb_lane #(
  parameter int BW = 32
) (
  input  logic          gnt,
  input  logic [BW-1:0] a,
  input  logic [BW-1:0] b,
  input  logic          sub,
  output logic [BW-1:0] a_m,
  output logic [BW-1:0] b_m,
  output logic          sub_m
);
  // Masked operands so the issue bus is a plain OR across lanes and reads 0 when idle
  assign a_m   = gnt ? a : '0;
  assign b_m   = gnt ? b : '0;
  assign sub_m = gnt & sub;
endmodule

module fpir_add_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int ADD_LATENCY   = 3,
  parameter int RSP_DEPTH     = 4,
  parameter int BW_FPIR_VALUE = 32
) (
  input  logic                               clk,
  input  logic                               rstnn,
  input  logic [NUM_REQ-1:0]                 req_valid,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic [NUM_REQ*BW_FPIR_VALUE-1:0]   req_a,
  input  logic [NUM_REQ*BW_FPIR_VALUE-1:0]   req_b,
  input  logic [NUM_REQ-1:0]                 req_sub,
  output logic                               add_issue,
  output logic [BW_FPIR_VALUE-1:0]           add_a,
  output logic [BW_FPIR_VALUE-1:0]           add_b,
  output logic                               add_sub,
  input  logic [BW_FPIR_VALUE-1:0]           add_result,
  output logic                               rsp_valid,
  input  logic                               rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]         rsp_tag,
  output logic [BW_FPIR_VALUE-1:0]           rsp_value,
  output logic                               busy
);
  localparam int BW    = BW_FPIR_VALUE;
  localparam int TAG_W = $clog2(NUM_REQ);
  localparam int PTR_W = $clog2(RSP_DEPTH);
  localparam int CRD_W = $clog2(RSP_DEPTH + 1);

  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [BW-1:0]    val_t;
  typedef struct packed {
    tag_t tag;
    val_t value;
  } rsp_t;

  logic [NUM_REQ-1:0][BW-1:0] a_vec, b_vec, a_m, b_m;
  logic [NUM_REQ-1:0]         sub_m, gnt;
  tag_t                       rr_ptr, gnt_idx, rr_idx;
  logic [TAG_W:0]             rr_sum;
  logic                       gnt_any, crd_ok, issue, pop;
  logic [CRD_W-1:0]           credit;

  assign a_vec = req_a;
  assign b_vec = req_b;

  // ---------------- round-robin grant ----------------
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    rr_sum  = '0;
    rr_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      rr_sum = {1'b0, rr_ptr} + (TAG_W+1)'(k);
      if (rr_sum >= (TAG_W+1)'(NUM_REQ)) rr_sum = rr_sum - (TAG_W+1)'(NUM_REQ);
      rr_idx = rr_sum[TAG_W-1:0];
      if (!gnt_any && req_valid[rr_idx]) begin
        gnt_any = 1'b1;
        gnt_idx = rr_idx;
      end
    end
  end

  // Gating with rstnn keeps the handshake quiet while reset is held
  assign crd_ok    = rstnn && (credit < CRD_W'(RSP_DEPTH));
  assign issue     = gnt_any & crd_ok;
  assign gnt       = issue ? (NUM_REQ'(1) << gnt_idx) : '0;
  assign req_ready = gnt;
  assign add_issue = issue;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    fpir_add_arb_lane #(.BW(BW)) u_lane (
      .gnt   (gnt[i]),
      .a     (a_vec[i]),
      .b     (b_vec[i]),
      .sub   (req_sub[i]),
      .a_m   (a_m[i]),
      .b_m   (b_m[i]),
      .sub_m (sub_m[i])
    );
  end

  always_comb begin
    add_a = '0;
    add_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      add_a = add_a | a_m[i];
      add_b = add_b | b_m[i];
    end
  end
  assign add_sub = |sub_m;

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn)     rr_ptr <= '0;
    else if (issue) rr_ptr <= (gnt_idx == tag_t'(NUM_REQ-1)) ? '0 : gnt_idx + tag_t'(1);
  end

  // ---------------- tag pipeline ----------------
  logic [ADD_LATENCY:0]       vld_pipe;
  logic [ADD_LATENCY:1]       vld_q;
  tag_t [ADD_LATENCY:0]       tag_pipe;
  tag_t [ADD_LATENCY:1]       tag_q;

  assign vld_pipe = {vld_q, issue};
  assign tag_pipe = {tag_q, gnt_idx};

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      vld_q <= '0;
      tag_q <= '0;
    end else begin
      vld_q <= vld_pipe[ADD_LATENCY-1:0];
      tag_q <= tag_pipe[ADD_LATENCY-1:0];
    end
  end

  // ---------------- response FIFO ----------------
  rsp_t           mem [RSP_DEPTH];
  logic [PTR_W:0] wr_ptr, rd_ptr;
  logic           wr_en;
  rsp_t           head;

  assign wr_en     = vld_pipe[ADD_LATENCY];
  assign rsp_valid = (wr_ptr != rd_ptr);
  assign pop       = rsp_valid & rsp_ready;
  assign head      = mem[rd_ptr[PTR_W-1:0]];
  assign rsp_tag   = rsp_valid ? head.tag   : '0;
  assign rsp_value = rsp_valid ? head.value : '0;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[PTR_W-1:0]] <= '{tag: tag_pipe[ADD_LATENCY], value: add_result};
  end

  // Extra pointer bit distinguishes full from empty; credit makes overflow impossible
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (pop)   rd_ptr <= rd_ptr + (PTR_W+1)'(1);
    end
  end

  // ---------------- credit ----------------
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn)             credit <= '0;
    else if (issue && !pop) credit <= credit + CRD_W'(1);
    else if (pop && !issue) credit <= credit - CRD_W'(1);
  end

  assign busy = (credit != '0);

endmodule

// File: tb/tb_fpir_add_arbiter.sv
// Directed bench for fpir_add_arbiter: behavioural adder, response scoreboard, fixed scenarios.

module tb_fpir_add_arbiter;
  localparam int NR = 4, LAT = 3, DEP = 4, BW = 32;

  logic              clk = 1'b0;
  logic              rstnn = 1'b0;
  logic [NR-1:0]     req_valid, req_ready, req_sub;
  logic [NR*BW-1:0]  req_a, req_b;
  logic              add_issue, add_sub;
  logic [BW-1:0]     add_a, add_b, add_result;
  logic              rsp_valid, rsp_ready, busy;
  logic [1:0]        rsp_tag;
  logic [BW-1:0]     rsp_value;

  logic [BW-1:0]     opa [NR];
  logic [BW-1:0]     opb [NR];
  logic [NR-1:0]     opsub;
  int                base = 0;

  assign req_a   = {opa[3], opa[2], opa[1], opa[0]};
  assign req_b   = {opb[3], opb[2], opb[1], opb[0]};
  assign req_sub = opsub;

  fpir_add_arbiter #(.NUM_REQ(NR), .ADD_LATENCY(LAT), .RSP_DEPTH(DEP), .BW_FPIR_VALUE(BW)) dut (
    .clk(clk), .rstnn(rstnn),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b), .req_sub(req_sub),
    .add_issue(add_issue), .add_a(add_a), .add_b(add_b), .add_sub(add_sub), .add_result(add_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tag(rsp_tag), .rsp_value(rsp_value),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Adder model: fixed LAT-cycle pipeline, garbage when nothing was issued, never reset
  logic [BW-1:0] apipe [LAT];
  always @(posedge clk) begin
    for (int k = LAT-1; k > 0; k--) apipe[k] <= apipe[k-1];
    apipe[0] <= add_issue ? (add_sub ? add_a - add_b : add_a + add_b) : 32'hDEAD_BEEF;
  end
  assign add_result = apipe[LAT-1];

  typedef struct packed {
    logic [1:0]    tag;
    logic [BW-1:0] val;
  } exp_t;
  exp_t exp_q [$];
  int   n_chk = 0, n_err = 0, n_issue = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [BW-1:0] model(input int i);
    return opsub[i] ? opa[i] - opb[i] : opa[i] + opb[i];
  endfunction

  task automatic refresh_ops();
    for (int i = 0; i < NR; i++) begin
      opa[i]   = 32'(base + i*3 + 100);
      opb[i]   = 32'(i + 5);
      opsub[i] = (((i + base/16) % 2) == 1);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
    base += 16;
    refresh_ops();
  endtask

  // Scoreboard: expectation built from the bench's own operands of the granted lane
  task automatic settle();
    exp_t e;
    #1;
    if (add_issue) begin
      n_issue++;
      for (int i = 0; i < NR; i++)
        if (req_ready[i]) begin
          e.tag = 2'(i);
          e.val = model(i);
          exp_q.push_back(e);
        end
    end
    if (rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) chk("rsp_unexpected", 64'(rsp_valid & rsp_ready), 64'd0);
      else begin
        e = exp_q.pop_front();
        chk("rsp_tag", 64'(rsp_tag), 64'(e.tag));
        chk("rsp_value", 64'(rsp_value), 64'(e.val));
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rstnn = 1'b0; req_valid = '1; rsp_ready = 1'b1; #1;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_add_issue", 64'(add_issue), 64'd0);
    chk("rst_add_a",     64'(add_a), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_tag",   64'(rsp_tag), 64'd0);
    chk("rst_rsp_value", 64'(rsp_value), 64'd0);
    chk("rst_busy",      64'(busy), 64'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rstnn = 1'b1; req_valid = '0; rsp_ready = 1'b0;
    n_issue = 0;
  endtask

  task automatic drain(input int cycles);
    for (int k = 0; k < cycles; k++) begin
      tick(); req_valid = '0; rsp_ready = 1'b1; settle();
    end
    chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("drain_busy", 64'(busy), 64'd0);
  endtask

  logic [BW-1:0] v1;
  int            g;

  initial begin
    req_valid = '0; rsp_ready = 1'b0;
    refresh_ops();

    // Single request, tag 2, response at t0+4
    do_reset();
    tick(); req_valid = 4'b0100; settle();
    v1 = model(2);
    chk("single_ready", 64'(req_ready), 64'b0100);
    chk("single_issue", 64'(add_issue), 64'd1);
    chk("single_add_a", 64'(add_a), 64'(opa[2]));
    chk("single_add_b", 64'(add_b), 64'(opb[2]));
    chk("single_add_sub", 64'(add_sub), 64'(opsub[2]));
    for (int k = 1; k <= 4; k++) begin
      tick(); req_valid = '0; rsp_ready = 1'b1; settle();
      if (k == 1) chk("idle_add_a_zero", 64'(add_a), 64'd0);
      chk("single_rsp_valid", 64'(rsp_valid), 64'(k == 4));
      if (k == 4) begin
        chk("single_rsp_tag", 64'(rsp_tag), 64'd2);
        chk("single_rsp_value", 64'(rsp_value), 64'(v1));
      end
    end
    tick(); rsp_ready = 1'b0; settle();
    chk("single_busy_after", 64'(busy), 64'd0);

    // Fairness: all requesters valid until 8 grants
    do_reset();
    g = 0;
    for (int c = 0; c < 20 && g < 8; c++) begin
      tick(); req_valid = 4'b1111; rsp_ready = 1'b1; settle();
      if (add_issue) begin
        chk("rr_grant", 64'(req_ready), 64'(4'b0001 << (g % 4)));
        g++;
      end
    end
    chk("rr_grant_count", 64'(g), 64'd8);
    drain(12);

    // Backpressure: consumer stalled, exactly RSP_DEPTH issues
    do_reset();
    for (int c = 0; c < 10; c++) begin
      tick(); req_valid = 4'b1111; rsp_ready = 1'b0; settle();
    end
    chk("bp_issue_count", 64'(n_issue), 64'd4);
    chk("bp_req_ready", 64'(req_ready), 64'd0);
    chk("bp_busy", 64'(busy), 64'd1);
    tick(); rsp_ready = 1'b1; settle();
    chk("bp_pop_no_issue", 64'(add_issue), 64'd0);
    n_issue = 0;
    for (int c = 0; c < 6; c++) begin
      tick(); rsp_ready = 1'b0; settle();
    end
    chk("bp_one_more_issue", 64'(n_issue), 64'd1);
    drain(12);

    // Pop and issue together at credit RSP_DEPTH-1
    do_reset();
    for (int c = 0; c < 3; c++) begin
      tick(); req_valid = 4'b0001; settle();
    end
    for (int c = 0; c < 4; c++) begin
      tick(); req_valid = '0; settle();
    end
    tick(); req_valid = 4'b0010; rsp_ready = 1'b1; settle();
    chk("pi_issue", 64'(add_issue), 64'd1);
    chk("pi_ready", 64'(req_ready), 64'b0010);
    chk("pi_rsp_valid", 64'(rsp_valid), 64'd1);
    n_issue = 0;
    for (int c = 0; c < 4; c++) begin
      tick(); req_valid = 4'b0001; rsp_ready = 1'b0; settle();
    end
    chk("pi_credit_left_one", 64'(n_issue), 64'd1);
    chk("pi_full_ready", 64'(req_ready), 64'd0);
    drain(12);

    // Reset mid-flight: late adder results must be ignored
    do_reset();
    for (int c = 0; c < 2; c++) begin
      tick(); req_valid = 4'b0001; settle();
    end
    tick(); req_valid = '0; rstnn = 1'b0;
    tick(); rstnn = 1'b1; exp_q.delete();
    for (int c = 0; c < 6; c++) begin
      tick(); rsp_ready = 1'b1; settle();
      chk("rmf_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rmf_busy", 64'(busy), 64'd0);
    end

    // Stall hold: head stays put while rsp_ready is low
    do_reset();
    tick(); req_valid = 4'b1000; settle();
    v1 = model(3);
    chk("hold_issue", 64'(add_issue), 64'd1);
    for (int k = 0; k < 10 && !rsp_valid; k++) begin
      tick(); req_valid = '0; rsp_ready = 1'b0; settle();
    end
    chk("hold_rsp_arrived", 64'(rsp_valid), 64'd1);
    for (int k = 0; k < 5; k++) begin
      tick(); settle();
      chk("hold_valid", 64'(rsp_valid), 64'd1);
      chk("hold_tag", 64'(rsp_tag), 64'd3);
      chk("hold_value", 64'(rsp_value), 64'(v1));
    end
    tick(); rsp_ready = 1'b1; settle();
    tick(); rsp_ready = 1'b0; settle();
    chk("hold_busy_after", 64'(busy), 64'd0);
    chk("hold_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
